// File: rtl/adc_spi_pkg.sv
// Shared constants and helpers for the ADC128S022-style serial responder.
package adc_spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int NUM_CH     = 8;
  localparam int ADDR_BITS  = 3;

  // Rising-edge indices (1-based) that carry the channel address bits.
  localparam int ADD2_RISE = 3;
  localparam int ADD1_RISE = 4;
  localparam int ADD0_RISE = 5;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic [NUM_CH*DATA_BITS-1:0] ch,
    input logic [ADDR_BITS-1:0]        addr
  );
    return {{(FRAME_BITS-DATA_BITS){1'b0}}, ch[DATA_BITS*addr +: DATA_BITS]};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, plus rise/fall pulses
// derived from one extra register after the synchronized value.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/adc_spi_responder.sv
// Serial ADC responder: answers ADC128S022-style 16-bit frames from a
// 96-bit bank of channel values, for hardware-in-the-loop testing.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | adc_cs_n high (or not yet armed); adc_sdat held at 0
//   ST_ACTIVE | frame in progress; shifting data, counting sclk rises
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            adc_cs_n,
  input  logic                            adc_sclk,
  input  logic                            adc_saddr,
  output logic                            adc_sdat,
  input  logic [NUM_CH*DATA_BITS-1:0]     ch_data,
  output logic [ADDR_BITS-1:0]            cur_addr,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            frame_abort
);

  localparam logic [4:0] RISE_ADD2    = 5'(ADD2_RISE);
  localparam logic [4:0] RISE_ADD1    = 5'(ADD1_RISE);
  localparam logic [4:0] RISE_ADD0    = 5'(ADD0_RISE);
  localparam logic [4:0] RISE_LAST    = 5'(FRAME_BITS);
  localparam logic [3:0] BITS_AFTER   = 4'(FRAME_BITS - 1);
  localparam logic [2:0] FLUSH_CYCLES = 3'(SYNC_STAGES + 1);

  logic cs_q, cs_rise, cs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic saddr_q, saddr_rise, saddr_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(adc_cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(adc_sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_saddr (
    .clk(clk), .reset(reset), .d(adc_saddr),
    .q(saddr_q), .rise(saddr_rise), .fall(saddr_fall)
  );

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [4:0]            rise_cnt;
  logic [3:0]            bits_left;
  logic [ADDR_BITS-1:0]  pend_addr;
  logic                  chained;
  logic                  armed;
  logic [2:0]            flush_cnt;
  logic [4:0]            rise_next;
  logic [FRAME_BITS-1:0] load_word;
  logic [FRAME_BITS-1:0] next_word;

  assign rise_next = rise_cnt + 5'd1;
  assign load_word = frame_word(ch_data, cur_addr);
  assign next_word = frame_word(ch_data, pend_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      rise_cnt    <= '0;
      bits_left   <= '0;
      pend_addr   <= '0;
      cur_addr    <= '0;
      chained     <= 1'b0;
      armed       <= 1'b0;
      flush_cnt   <= '0;
      adc_sdat    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;

      // The synchronizers come out of reset at 1; a falling edge is only
      // trusted once they have flushed and adc_cs_n has been seen high.
      if (flush_cnt != FLUSH_CYCLES) flush_cnt <= flush_cnt + 3'd1;
      else if (cs_q)                 armed     <= 1'b1;

      case (state)
        ST_IDLE: begin
          adc_sdat <= 1'b0;
          if (cs_fall && armed) begin
            shift_reg <= load_word;
            adc_sdat  <= load_word[FRAME_BITS-1];
            bits_left <= BITS_AFTER;
            rise_cnt  <= '0;
            chained   <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (cs_rise) begin
            // A reload that has seen no sclk rise yet follows a completed
            // frame, so deselecting there is a normal frame end.
            if (!(chained && rise_cnt == 5'd0)) frame_abort <= 1'b1;
            adc_sdat <= 1'b0;
            rise_cnt <= '0;
            chained  <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else if (sclk_rise) begin
            rise_cnt <= rise_next;
            chained  <= 1'b0;
            if (rise_next == RISE_ADD2) pend_addr[2] <= saddr_q;
            if (rise_next == RISE_ADD1) pend_addr[1] <= saddr_q;
            if (rise_next == RISE_ADD0) pend_addr[0] <= saddr_q;
            if (rise_next == RISE_LAST) begin
              cur_addr   <= pend_addr;
              frame_done <= 1'b1;
              rise_cnt   <= '0;
              shift_reg  <= next_word;
              adc_sdat   <= next_word[FRAME_BITS-1];
              bits_left  <= BITS_AFTER;
              chained    <= 1'b1;
            end
          end else if (sclk_fall && bits_left != 4'd0) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
            adc_sdat  <= shift_reg[FRAME_BITS-2];
            bits_left <= bits_left - 4'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
